// File: rtl/spi_master.sv
// spi_master: single-clock SPI master for 10-bit command frames.
// One bit moves per clk cycle. There is no SCLK output because the slave
// runs on the same clock. Frames of type 2'b11 (read data) are followed by
// a turnaround and an 8-bit MISO reply, which is delivered on rsp_data
// together with a one-cycle rsp_valid pulse.
// Optional feature macro: SPI_MASTER_ABORT_EN. When it is defined, the module
// gains an abort input that ends an in-flight frame early.
module spi_master #(
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT_OUT,
    S_TURN,
    S_SHIFT_IN,
    S_GAP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [9:0]  r_sh_out;
  logic [7:0]  r_sh_in;
  logic        r_is_rd;
  logic        w_abort;

`ifdef SPI_MASTER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Frame sequencer. Every output is registered and is set to the value it
  // must have in the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (w_abort && (r_state inside {S_START, S_SHIFT_OUT, S_TURN, S_SHIFT_IN})) begin
        // An abort drops select right away and still keeps the normal gap.
        r_state   <= S_GAP;
        r_cnt     <= 4'd0;
        SS_n      <= 1'b1;
        MOSI      <= 1'b0;
        cmd_ready <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              r_sh_out  <= cmd_data;
              r_is_rd   <= (cmd_data[9:8] == 2'b11);
              r_state   <= S_START;
              SS_n      <= 1'b0;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
          S_START: begin
            // Put the MSB on the line for the first SHIFT_OUT cycle.
            MOSI     <= r_sh_out[9];
            r_sh_out <= {r_sh_out[8:0], 1'b0};
            r_cnt    <= 4'd0;
            r_state  <= S_SHIFT_OUT;
          end
          S_SHIFT_OUT: begin
            if (r_cnt == 4'd9) begin
              r_cnt <= 4'd0;
              MOSI  <= 1'b0;
              if (r_is_rd) begin
                r_state <= S_TURN;
              end else begin
                r_state <= S_GAP;
                SS_n    <= 1'b1;
              end
            end else begin
              MOSI     <= r_sh_out[9];
              r_sh_out <= {r_sh_out[8:0], 1'b0};
              r_cnt    <= r_cnt + 4'd1;
            end
          end
          S_TURN: begin
            if (r_cnt == TURN_LAST) begin
              r_cnt   <= 4'd0;
              r_state <= S_SHIFT_IN;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_SHIFT_IN: begin
            // The first sample shifts all the way up to bit 7.
            r_sh_in <= {r_sh_in[6:0], MISO};
            if (r_cnt == 4'd7) begin
              rsp_data  <= {r_sh_in[6:0], MISO};
              rsp_valid <= 1'b1;
              r_cnt     <= 4'd0;
              r_state   <= S_GAP;
              SS_n      <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_cnt     <= 4'd0;
              r_state   <= S_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed testbench for spi_master with default parameters.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge. Cycle T+c is the c-th cycle after the accept edge T.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort;
`endif

  int checks = 0;
  int errors = 0;

  spi_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
`ifdef SPI_MASTER_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_data = 10'h3FF;
    repeat (3) tick();
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy: got %b want 0", busy); end
    cmd_valid = 1'b0;
    tick();
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rel_no_accept_ss_n: got %b want 1", SS_n); end
  endtask

  task automatic test_write;
    bit ok;
    logic [9:0] wd = 10'b01_1010_0101;
    logic [9:0] got = '0;
    logic mosi_start = 1'b1;
    logic busy_start = 1'b0;
    logic ss_after = 1'b0;
    int ss_low = 0, rv_cnt = 0, ready_at = 0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_ready_timeout: got 0 want 1"); end
    cmd_valid = 1'b1; cmd_data = wd;
    tick();
    cmd_valid = 1'b0; cmd_data = 10'h000;
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) begin mosi_start = MOSI; busy_start = busy; end
      if (c >= 2 && c <= 11) got[11-c] = MOSI;
      if (c == 12) ss_after = SS_n;
      if (SS_n === 1'b0) ss_low++;
      if (rsp_valid === 1'b1) rv_cnt++;
      if (cmd_ready === 1'b1 && ready_at == 0) ready_at = c;
      if (c < 16) tick();
    end
    checks++; if (got !== wd) begin errors++; $display("FAIL wr_mosi: got %b want %b", got, wd); end
    checks++; if (mosi_start !== 1'b0) begin errors++; $display("FAIL wr_start_mosi: got %b want 0", mosi_start); end
    checks++; if (busy_start !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy_start); end
    checks++; if (ss_low != 11) begin errors++; $display("FAIL wr_ss_low_len: got %0d want 11", ss_low); end
    checks++; if (ss_after !== 1'b1) begin errors++; $display("FAIL wr_ss_gap: got %b want 1", ss_after); end
    checks++; if (rv_cnt != 0) begin errors++; $display("FAIL wr_no_rsp: got %0d want 0", rv_cnt); end
    checks++; if (ready_at != 13) begin errors++; $display("FAIL wr_ready_at: got %0d want 13", ready_at); end
  endtask

  task automatic test_read;
    bit ok;
    logic [9:0] rd = 10'b11_0000_0000;
    logic [7:0] resp = 8'hA5;
    logic [9:0] got = '0;
    logic [7:0] rv_data = '0;
    int ss_low = 0, ss_last = 0, rv_cnt = 0, rv_at = 0, ready_at = 0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_ready_timeout: got 0 want 1"); end
    cmd_valid = 1'b1; cmd_data = rd;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      MISO = (c >= 14 && c <= 21) ? resp[21-c] : 1'b1;
      if (c >= 2 && c <= 11) got[11-c] = MOSI;
      if (SS_n === 1'b0) begin ss_low++; ss_last = c; end
      if (rsp_valid === 1'b1) begin rv_cnt++; rv_at = c; rv_data = rsp_data; end
      if (cmd_ready === 1'b1 && ready_at == 0) ready_at = c;
      if (c < 26) tick();
    end
    MISO = 1'b0;
    checks++; if (got !== rd) begin errors++; $display("FAIL rd_mosi: got %b want %b", got, rd); end
    checks++; if (ss_low != 21) begin errors++; $display("FAIL rd_ss_low_len: got %0d want 21", ss_low); end
    checks++; if (ss_last != 21) begin errors++; $display("FAIL rd_ss_last: got %0d want 21", ss_last); end
    checks++; if (rv_cnt != 1) begin errors++; $display("FAIL rd_rv_count: got %0d want 1", rv_cnt); end
    checks++; if (rv_at != 22) begin errors++; $display("FAIL rd_rv_at: got %0d want 22", rv_at); end
    checks++; if (rv_data !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", rv_data); end
    checks++; if (ready_at != 23) begin errors++; $display("FAIL rd_ready_at: got %0d want 23", ready_at); end
    checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL rd_data_hold: got %h want a5", rsp_data); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [9:0] fa = 10'b10_1100_1010;
    logic [9:0] fb = 10'b00_0101_0011;
    logic [9:0] got1 = '0, got2 = '0;
    logic ss_a [0:31];
    logic mosi_a [0:31];
    int second_start = 0, high_cnt = 0, low2 = 0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_ready_timeout: got 0 want 1"); end
    cmd_valid = 1'b1; cmd_data = fa;
    tick();
    cmd_data = fb;
    for (int c = 1; c <= 30; c++) begin
      ss_a[c] = SS_n;
      mosi_a[c] = MOSI;
      if (c >= 13 && SS_n === 1'b0) cmd_valid = 1'b0;
      if (c < 30) tick();
    end
    cmd_valid = 1'b0;
    for (int c = 2; c <= 11; c++) got1[11-c] = mosi_a[c];
    for (int c = 12; c <= 30; c++) begin
      if (second_start == 0 && ss_a[c] === 1'b0) second_start = c;
    end
    if (second_start >= 12 && second_start <= 20) begin
      for (int c = 12; c < second_start; c++) if (ss_a[c] === 1'b1) high_cnt++;
      for (int k = 0; k < 10; k++) got2[9-k] = mosi_a[second_start+1+k];
      for (int c = second_start; c <= 30; c++) if (ss_a[c] === 1'b0) low2++;
    end
    checks++; if (second_start != 14) begin errors++; $display("FAIL b2b_second_start: got %0d want 14", second_start); end
    checks++; if (high_cnt != 2) begin errors++; $display("FAIL b2b_ss_high: got %0d want 2", high_cnt); end
    checks++; if (got1 !== fa) begin errors++; $display("FAIL b2b_mosi1: got %b want %b", got1, fa); end
    checks++; if (got2 !== fb) begin errors++; $display("FAIL b2b_mosi2: got %b want %b", got2, fb); end
    checks++; if (low2 != 11) begin errors++; $display("FAIL b2b_ss_low2: got %0d want 11", low2); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int rv_cnt = 0, ss_low = 0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_ready_timeout: got 0 want 1"); end
    MISO = 1'b1;
    cmd_valid = 1'b1; cmd_data = 10'b11_1111_1111;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    checks++; if (MOSI !== 1'b1 || SS_n !== 1'b0) begin errors++; $display("FAIL rm_bit4: got mosi=%b ss_n=%b want 1 0", MOSI, SS_n); end
    rst = 1'b1;
    tick();
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rm_ss_n: got %b want 1", SS_n); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rm_rsp_data: got %h want 00", rsp_data); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_idle_ready: got %b want 1", cmd_ready); end
    for (int c = 0; c < 25; c++) begin
      if (rsp_valid === 1'b1) rv_cnt++;
      if (SS_n === 1'b0) ss_low++;
      tick();
    end
    checks++; if (rv_cnt != 0) begin errors++; $display("FAIL rm_no_rsp: got %0d want 0", rv_cnt); end
    checks++; if (ss_low != 0) begin errors++; $display("FAIL rm_ss_stays_high: got %0d want 0", ss_low); end
    MISO = 1'b0;
  endtask

`ifdef SPI_MASTER_ABORT_EN
  task automatic test_abort;
    bit ok;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ab_ready_timeout: got 0 want 1"); end
    MISO = 1'b1;
    cmd_valid = 1'b1; cmd_data = 10'b11_0000_0001;
    tick();
    cmd_valid = 1'b0;
    repeat (25) tick();
    checks++; if (rsp_data !== 8'hFF) begin errors++; $display("FAIL ab_first_read: got %h want ff", rsp_data); end
    MISO = 1'b0;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_data = 10'b11_0000_0010;
    tick();
    cmd_valid = 1'b0;
    repeat (16) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL ab_ss_n: got %b want 1", SS_n); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ab_rsp_valid: got %b want 0", rsp_valid); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ab_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_data !== 8'hFF) begin errors++; $display("FAIL ab_rsp_kept: got %h want ff", rsp_data); end
  endtask
`endif

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 10'h000; MISO = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_MASTER_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
